// File: rtl/if_stage_if.sv
// if_stage_if: byte-wide read port between the fetch stage and the memory
// controller.
//   mem_req   : byte read request (driven by the fetch stage)
//   mem_addr  : byte address of the request (driven by the fetch stage)
//   mem_valid : one-cycle pulse, byte for the current request is on mem_rdata
//   mem_rdata : returned byte
// Modports: master = fetch stage, slave = memory controller.
// Also provides the default `StallSignalLen (width of the pipeline stall vector).

`ifndef StallSignalLen
`define StallSignalLen 6
`endif

interface if_stage_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage, producer side of the IF/ID register.
// Keeps the PC, reads each 32-bit instruction as four little-endian bytes
// over the 8-bit memory port, and presents {pc_o, inst_o, inst_valid}.
// Redirects on jump_flag (priority over stall), holds on stall_signal[0].
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   jump_flag     : redirect request from EX
//   jump_addr     : redirect target (word aligned)
//   stall_signal  : stall vector, bit 0 holds IF
//   mem           : if_stage_if.master byte read port
//   pc_o, inst_o  : presented PC / instruction (0 when inst_valid=0)
//   inst_valid    : pc_o/inst_o hold a fetched instruction
// Optional feature: define ICACHE_EN for a direct-mapped, one-word-per-line
// I-cache of ICACHE_LINES entries (power of 2, at least 2).

module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_flag,
  input  logic [31:0]                jump_addr,
  input  logic [`StallSignalLen-1:0] stall_signal,
  if_stage_if.master                 mem,
  output logic [31:0]                pc_o,
  output logic [31:0]                inst_o,
  output logic                       inst_valid
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] B0    = 3'd1;
  localparam logic [2:0] B1    = 3'd2;
  localparam logic [2:0] B2    = 3'd3;
  localparam logic [2:0] B3    = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] FLUSH = 3'd6;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [23:0] byte_buf;   // bytes 0..2; byte 3 goes straight into inst_o
  logic        in_byte;
  logic [1:0]  byte_idx;
  logic [31:0] word_next;
  logic        hold;
  logic        hit;
  logic [31:0] hit_word;
  logic        stall_unused;

  assign hold         = stall_signal[0];
  assign stall_unused = ^stall_signal[`StallSignalLen-1:1];
  assign word_next    = {mem.mem_rdata, byte_buf};

  always_comb begin
    in_byte  = 1'b1;
    byte_idx = 2'd0;
    case (state)
      B0:      byte_idx = 2'd0;
      B1:      byte_idx = 2'd1;
      B2:      byte_idx = 2'd2;
      B3:      byte_idx = 2'd3;
      default: in_byte  = 1'b0;
    endcase
  end

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    fill;

  assign idx      = pc[IDX_W+1:2];
  assign tag      = pc[31:IDX_W+2];
  assign hit      = line_valid[idx] && (tag_mem[idx] == tag);
  assign hit_word = data_mem[idx];
  // A line is written only when a miss fetch completes; a redirect on the
  // final byte aborts the fetch and therefore the fill.
  assign fill     = !jump_flag && (state == B3) && mem.mem_valid;

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= word_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[idx] <= 1'b1;
    end
  end
`else
  logic [31:0] lines_unused;
  assign lines_unused = ICACHE_LINES;
  assign hit          = 1'b0;
  assign hit_word     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      byte_buf     <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      pc_o         <= '0;
      inst_o       <= '0;
      inst_valid   <= 1'b0;
    end else if (jump_flag) begin
      pc          <= jump_addr;
      byte_buf    <= '0;
      mem.mem_req <= 1'b0;
      pc_o        <= '0;
      inst_o      <= '0;
      inst_valid  <= 1'b0;
      // A request accepted but not yet answered must be drained in FLUSH so
      // its late byte is not taken as part of the new fetch.
      if (state == FLUSH) begin
        state <= mem.mem_valid ? IDLE : FLUSH;
      end else if (in_byte && !mem.mem_valid) begin
        state <= FLUSH;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state      <= DONE;
            pc_o       <= pc;
            inst_o     <= hit_word;
            inst_valid <= 1'b1;
          end else begin
            state        <= B0;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= pc;
          end
        end
        B0, B1, B2: begin
          if (mem.mem_valid) begin
            byte_buf[{byte_idx, 3'b000} +: 8] <= mem.mem_rdata;
            mem.mem_addr <= pc + {30'd0, byte_idx} + 32'd1;
            state        <= state + 3'd1;
          end
        end
        B3: begin
          if (mem.mem_valid) begin
            mem.mem_req <= 1'b0;
            state       <= DONE;
            pc_o        <= pc;
            inst_o      <= word_next;
            inst_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (!hold) begin
            pc         <= pc + 32'd4;
            state      <= IDLE;
            pc_o       <= '0;
            inst_o     <= '0;
            inst_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (mem.mem_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps

module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       jump_flag;
  logic [31:0]                jump_addr;
  logic [`StallSignalLen-1:0] stall_signal;
  logic [31:0]                pc_o;
  logic [31:0]                inst_o;
  logic                       inst_valid;

  if_stage_if mem_bus ();

  if_stage #(.RESET_PC(RESET_PC), .ICACHE_LINES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .stall_signal (stall_signal),
    .mem          (mem_bus),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Byte memory (1 KiB image, address aliased modulo 1024).
  logic [7:0]  mem [0:1023];
  logic        prev_req;
  logic        prev_valid;
  logic [31:0] prev_addr;

  // Memory responder, latency 1: a request that was up with no byte returned
  // across a rising edge is answered for the following edge.
  always @(negedge clk) begin
    if (rst) begin
      mem_bus.mem_valid = 1'b0;
      mem_bus.mem_rdata = 8'h00;
      prev_req   = 1'b0;
      prev_valid = 1'b0;
      prev_addr  = 32'h0;
    end else begin
      if (prev_req && !prev_valid) begin
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_rdata = mem[prev_addr[9:0]];
      end else begin
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_rdata = 8'h00;
      end
      prev_req   = mem_bus.mem_req;
      prev_addr  = mem_bus.mem_addr;
      prev_valid = mem_bus.mem_valid;
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    jump_flag    = 1'b0;
    jump_addr    = 32'h0;
    stall_signal = '0;
    rst          = 1'b1;
    repeat (3) step();
    checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_bus.mem_req); else passed++;
    checks++; if (mem_bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_bus.mem_addr); else passed++;
    checks++; if (pc_o !== 32'h0) $display("FAIL reset_pc_o got %h exp 0", pc_o); else passed++;
    checks++; if (inst_o !== 32'h0) $display("FAIL reset_inst_o got %h exp 0", inst_o); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b exp 0", inst_valid); else passed++;
  endtask

  task automatic test_first_fetch();
    bit found;
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_bus.mem_req === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL first_req_timeout got none exp mem_req"); else passed++;
    checks++; if (mem_bus.mem_addr !== RESET_PC) $display("FAIL first_mem_addr got %h exp %h", mem_bus.mem_addr, RESET_PC); else passed++;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL first_valid_timeout got none exp inst_valid"); else passed++;
    checks++; if (pc_o !== 32'h0) $display("FAIL first_pc_o got %h exp 0", pc_o); else passed++;
    checks++; if (inst_o !== 32'h0000_0513) $display("FAIL first_inst_o got %h exp 00000513", inst_o); else passed++;
    step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL first_valid_clear got %b exp 0", inst_valid); else passed++;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_bus.mem_req === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found || mem_bus.mem_addr !== 32'h4) $display("FAIL second_mem_addr got %h exp 00000004", mem_bus.mem_addr); else passed++;
  endtask

  task automatic test_jump_flush();
    bit found;
    bit saw_iv;
    int pulses;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.mem_req === 1'b1 && mem_bus.mem_addr === 32'h5 && mem_bus.mem_valid === 1'b0) begin found = 1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL flush_reach_b1 got none exp outstanding byte at 0x5"); else passed++;
    jump_flag = 1'b1;
    jump_addr = 32'h100;
    step();
    jump_flag = 1'b0;
    found  = 0;
    saw_iv = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.mem_req === 1'b1) begin found = 1; break; end
      if (mem_bus.mem_valid === 1'b1) pulses++;
      if (inst_valid !== 1'b0) saw_iv = 1;
      step();
    end
    checks++; if (!found) $display("FAIL flush_req_timeout got none exp mem_req"); else passed++;
    checks++; if (pulses != 1) $display("FAIL flush_swallow got %0d exp 1", pulses); else passed++;
    checks++; if (mem_bus.mem_addr !== 32'h100) $display("FAIL flush_next_addr got %h exp 00000100", mem_bus.mem_addr); else passed++;
    checks++; if (saw_iv) $display("FAIL flush_no_valid got 1 exp 0"); else passed++;
  endtask

  task automatic test_stall();
    bit found;
    logic [31:0] exp_word;
    exp_word = word_at(32'h100);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL stall_valid_timeout got none exp inst_valid"); else passed++;
    stall_signal[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (inst_valid !== 1'b1) $display("FAIL stall_hold_valid cycle %0d got %b exp 1", c, inst_valid); else passed++;
      checks++; if (pc_o !== 32'h100) $display("FAIL stall_hold_pc cycle %0d got %h exp 00000100", c, pc_o); else passed++;
      checks++; if (inst_o !== exp_word) $display("FAIL stall_hold_inst cycle %0d got %h exp %h", c, inst_o, exp_word); else passed++;
      checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL stall_no_req cycle %0d got %b exp 0", c, mem_bus.mem_req); else passed++;
    end
    stall_signal[0] = 1'b0;
    step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL stall_release_valid got %b exp 0", inst_valid); else passed++;
    step();
    checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h104) $display("FAIL stall_next_fetch got req %b addr %h exp req 1 addr 00000104", mem_bus.mem_req, mem_bus.mem_addr); else passed++;
  endtask

  task automatic test_jump_stall();
    bit found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found || pc_o !== 32'h104) $display("FAIL jstall_done got %h exp 00000104", pc_o); else passed++;
    stall_signal[0] = 1'b1;
    jump_flag       = 1'b1;
    jump_addr       = 32'h200;
    step();
    jump_flag       = 1'b0;
    stall_signal[0] = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL jstall_valid got %b exp 0", inst_valid); else passed++;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_bus.mem_req === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found || mem_bus.mem_addr !== 32'h200) $display("FAIL jstall_next_addr got %h exp 00000200", mem_bus.mem_addr); else passed++;
  endtask

  // Reference model: the instruction stream is the sequence of word-aligned
  // PCs implied by redirects and consumed instructions; each presented
  // instruction must be the memory word at the expected PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] diff;
    bit          do_jump;
    bit          do_stall;
    logic [31:0] target;
    int          completed;
    int          idle_cycles;
    bit          stuck;
    exp_pc      = 32'h200;
    completed   = 0;
    idle_cycles = 0;
    stuck       = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (inst_valid === 1'b1) begin
        idle_cycles = 0;
        checks++; if (pc_o !== exp_pc) $display("FAIL rand_pc_o cycle %0d got %h exp %h", cyc, pc_o, exp_pc); else passed++;
        checks++; if (inst_o !== word_at(exp_pc)) $display("FAIL rand_inst_o cycle %0d got %h exp %h", cyc, inst_o, word_at(exp_pc)); else passed++;
      end else begin
        idle_cycles++;
        checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0) $display("FAIL rand_bubble cycle %0d got pc %h inst %h exp 0 0", cyc, pc_o, inst_o); else passed++;
      end
      if (mem_bus.mem_req === 1'b1) begin
        diff = mem_bus.mem_addr - exp_pc;
        checks++; if (diff >= 32'd4) $display("FAIL rand_mem_addr cycle %0d got %h exp %h..+3", cyc, mem_bus.mem_addr, exp_pc); else passed++;
      end
      if (idle_cycles > 200) begin stuck = 1; break; end
      // Keep random traffic out of the region used by the directed tests.
      do_jump  = ($urandom_range(0, 15) == 0) || (exp_pc >= 32'h80 && exp_pc < 32'h300);
      do_stall = ($urandom_range(0, 2) == 0);
      target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'h300 + ($urandom_range(0, 63) << 2));
      jump_flag    = do_jump;
      jump_addr    = target;
      stall_signal = `StallSignalLen'($urandom);
      stall_signal[0] = do_stall;
      if (do_jump) exp_pc = target;
      else if (inst_valid === 1'b1 && !do_stall) begin
        exp_pc = exp_pc + 32'd4;
        completed++;
      end
      step();
    end
    jump_flag    = 1'b0;
    stall_signal = '0;
    checks++; if (stuck) $display("FAIL rand_progress got stall >200 cycles exp inst_valid"); else passed++;
    checks++; if (completed < 50) $display("FAIL rand_completed got %0d exp >=50", completed); else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    jump_flag = 1'b1;
    jump_addr = 32'h280;
    step();
    jump_flag = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (mem_bus.mem_req === 1'b1 && mem_bus.mem_addr === 32'h282) begin found = 1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL rmid_reach_b2 got none exp mem_addr 00000282"); else passed++;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL rmid_mem_req got %b exp 0", mem_bus.mem_req); else passed++;
    checks++; if (mem_bus.mem_addr !== 32'h0) $display("FAIL rmid_mem_addr got %h exp 0", mem_bus.mem_addr); else passed++;
    checks++; if (inst_valid !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) $display("FAIL rmid_outputs got %b %h %h exp 0 0 0", inst_valid, pc_o, inst_o); else passed++;
    repeat (2) step();
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_bus.mem_req === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found || mem_bus.mem_addr !== RESET_PC) $display("FAIL rmid_first_addr got %h exp %h", mem_bus.mem_addr, RESET_PC); else passed++;
  endtask

`ifdef ICACHE_EN
  task automatic test_icache();
    bit found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found || pc_o !== 32'h0) $display("FAIL ic_pass1_pc0 got %h exp 0", pc_o); else passed++;
    step();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid === 1'b1) begin found = 1; break; end
      step();
    end
    checks++; if (!found || pc_o !== 32'h4) $display("FAIL ic_pass1_pc4 got %h exp 00000004", pc_o); else passed++;
    jump_flag = 1'b1;
    jump_addr = 32'h0;
    step();
    jump_flag = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_bus.mem_req !== 1'b0) $display("FAIL ic_idle0 got valid %b req %b exp 0 0", inst_valid, mem_bus.mem_req); else passed++;
    step();
    checks++; if (inst_valid !== 1'b1 || pc_o !== 32'h0 || inst_o !== word_at(32'h0)) $display("FAIL ic_hit0 got %b %h %h exp 1 0 %h", inst_valid, pc_o, inst_o, word_at(32'h0)); else passed++;
    checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL ic_hit0_req got %b exp 0", mem_bus.mem_req); else passed++;
    step();
    checks++; if (inst_valid !== 1'b0 || mem_bus.mem_req !== 1'b0) $display("FAIL ic_idle4 got valid %b req %b exp 0 0", inst_valid, mem_bus.mem_req); else passed++;
    step();
    checks++; if (inst_valid !== 1'b1 || pc_o !== 32'h4 || inst_o !== word_at(32'h4)) $display("FAIL ic_hit4 got %b %h %h exp 1 4 %h", inst_valid, pc_o, inst_o, word_at(32'h4)); else passed++;
    checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL ic_hit4_req got %b exp 0", mem_bus.mem_req); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h00;
    mem[3] = 8'h00;
    test_reset();
    test_first_fetch();
    test_jump_flush();
    test_stall();
    test_jump_stall();
    test_random();
    test_reset_mid();
`ifdef ICACHE_EN
    test_icache();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
